// File: rtl/serializer_pkg.sv
// Shared types and defaults for the serializer controller.
// Optional parity support is selected by SERIALIZER_PARITY_EN in serializer_ctrl.
package serializer_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register; load has priority over shift.
// dir_i=1 presents and shifts out the MSB end, dir_i=0 the LSB end.
module piso_shift #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic             dir_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             bit_o
);

   logic [WIDTH-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = din_i;
      end else if (shift_i) begin
         sr_d = dir_i ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) sr_q <= '0;
      else         sr_q <= sr_d;
   end

   assign bit_o = dir_i ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serializer_ctrl.sv
// Word-to-bit serializer with valid/ready input and framed serial output, 1-cycle accept latency.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module serializer_ctrl
   import serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_first,
   output logic             frame_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept, last_bit, load, shift, data_bit;
`ifdef SERIALIZER_PARITY_EN
   logic          par_q, par_d;
`endif

   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`ifdef SERIALIZER_PARITY_EN
   assign din_ready = !clear && ((state_q == IDLE) || (state_q == PARITY));
`else
   assign din_ready = !clear && ((state_q == IDLE) || last_bit);
`endif
   assign accept = din_valid && din_ready;
   assign busy   = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = '0;
               load    = 1'b1;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               shift = 1'b1;
               cnt_d = cnt_q + CW'(1);
            end else begin
`ifdef SERIALIZER_PARITY_EN
               state_d = PARITY;
`else
               // A same-edge accept chains the next frame with no idle gap.
               if (accept) begin
                  cnt_d = '0;
                  load  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = '0;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

`ifdef SERIALIZER_PARITY_EN
   always_comb begin
      par_d = par_q;
      if (load) par_d = ^din;
   end
`endif

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   piso_shift #(.WIDTH(WIDTH)) u_piso (
      .clk_i   (clk),
      .clear_i (clear),
      .load_i  (load),
      .shift_i (shift),
      .dir_i   (MSB_FIRST != 0),
      .din_i   (din),
      .bit_o   (data_bit)
   );

   always_comb begin
      sout        = 1'b0;
      sout_valid  = 1'b0;
      frame_first = 1'b0;
      frame_last  = 1'b0;
      if (state_q == SHIFT) begin
         sout        = data_bit;
         sout_valid  = 1'b1;
         frame_first = (cnt_q == '0);
`ifndef SERIALIZER_PARITY_EN
         frame_last  = last_bit;
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      else if (state_q == PARITY) begin
         sout       = par_q;
         sout_valid = 1'b1;
         frame_last = 1'b1;
      end
`endif
   end

endmodule
